// File: rtl/sha256_host.sv
// sha256_host: byte-stream front end for the sha256 engine.
// Packs the message into shared memory, starts the engine, streams the digest.
module sha256_host #(
  parameter logic [15:0] MSG_BASE  = 16'h0000,
  parameter logic [15:0] OUT_BASE  = 16'h0100,
  parameter int unsigned MAX_BYTES = 1024,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        eng_start,
  output logic [31:0] eng_message_addr,
  output logic [31:0] eng_size,
  output logic [31:0] eng_output_addr,
  input  logic        eng_done,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic        dig_last,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_timeout
);
  typedef enum logic [2:0] {
    LOAD, START, WAIT, RD_ADDR, RD_WAIT, RD_CAP, EMIT
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_BYTES);
  localparam logic [31:0] TO_N  = 32'(TIMEOUT);

  state_t      state, next;
  logic [15:0] count;
  logic [31:0] pack;
  logic [31:0] word;
  logic [2:0]  idx;
  logic [31:0] tcnt;
  logic        done_q;
  logic        accept;
  logic        room;
  logic        flush;
  logic        done_edge;
  logic        expired;

  always_comb begin
    accept    = in_valid & in_ready & (state == LOAD);
    room      = count < MAX_N;
    flush     = (count[1:0] == 2'd3) | in_last |
                (count == MAX_N - 16'd1);
    word      = pack | ({in_data, 24'b0} >> {count[1:0], 3'b0});
    done_edge = eng_done & ~done_q;
    expired   = tcnt >= TO_N;
    next      = state;
    unique case (state)
      LOAD:    if (accept && in_last) next = START;
      START:   next = WAIT;
      WAIT: begin
        if (done_edge)    next = RD_ADDR;
        else if (expired) next = LOAD;
      end
      RD_ADDR: next = RD_WAIT;
      RD_WAIT: next = RD_CAP;
      RD_CAP:  next = EMIT;
      EMIT: begin
        if (dig_ready) next = (idx == 3'd7) ? LOAD : RD_ADDR;
      end
      default: next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready         <= 1'b0;
      eng_start        <= 1'b0;
      eng_message_addr <= '0;
      eng_size         <= '0;
      eng_output_addr  <= '0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      dig_valid        <= 1'b0;
      dig_data         <= '0;
      dig_last         <= 1'b0;
      busy             <= 1'b0;
      err_overflow     <= 1'b0;
      err_timeout      <= 1'b0;
      count            <= '0;
      pack             <= '0;
      idx              <= '0;
      tcnt             <= '0;
      done_q           <= 1'b0;
    end else begin
      mem_we           <= 1'b0;
      eng_start        <= 1'b0;
      eng_message_addr <= {16'b0, MSG_BASE};
      eng_output_addr  <= {16'b0, OUT_BASE};
      in_ready         <= (next == LOAD);
      busy             <= (next != LOAD);
      done_q           <= eng_done;
      unique case (state)
        LOAD: begin
          if (accept) begin
            // first byte of a new message clears stale errors
            if (count == 16'd0) begin
              err_overflow <= 1'b0;
              err_timeout  <= 1'b0;
            end
            if (room) begin
              count <= count + 16'd1;
              if (flush) begin
                mem_we         <= 1'b1;
                mem_addr       <= MSG_BASE + {2'b00, count[15:2]};
                mem_write_data <= word;
                pack           <= '0;
              end else begin
                pack <= word;
              end
            end else begin
              err_overflow <= 1'b1;
            end
            if (in_last) begin
              eng_size <= room ? (32'(count) + 32'd1) : 32'(MAX_N);
              count    <= '0;
              pack     <= '0;
            end
          end
        end
        START: begin
          eng_start <= 1'b1;
          tcnt      <= '0;
        end
        WAIT: begin
          if (!done_edge) begin
            if (expired) err_timeout <= 1'b1;
            else         tcnt <= tcnt + 32'd1;
          end
        end
        RD_ADDR: mem_addr <= OUT_BASE + {13'b0, idx};
        RD_WAIT: ;
        RD_CAP: begin
          dig_data  <= mem_read_data;
          dig_valid <= 1'b1;
          dig_last  <= (idx == 3'd7);
        end
        EMIT: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            dig_last  <= 1'b0;
            idx       <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
